// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ADC/SBC ALU: one full adder processes the operands LSB first, one bit per clock.
// Result and flags become valid WIDTH cycles after start is accepted, and they hold until the next accepted start.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic             ovf;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             last;
    logic             sum_bit;
    logic             carry_nxt;

    full_adder u_fa (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (carry),
        .s    (sum_bit),
        .cout (carry_nxt)
    );

    assign last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The result register is not cleared on load: WIDTH shifts fully replace it,
    // so the previous result stays readable during a back-to-back DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= subtract ? ~b : b;
            carry <= carry_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= carry_nxt;
            cnt    <= cnt + CW'(1);
            if (last) begin
                ovf <= carry ^ carry_nxt;
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign result    = res_sr;
    assign carry_out = carry;
    assign overflow  = ovf;
    assign zero      = (res_sr == '0);
    assign negative  = res_sr[WIDTH-1];
endmodule
